// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: drives init/step enables of the iterative multiplier/divider
// and commits their result through the shared HI/LO write port.
module muldiv_sequencer #(
   parameter int ITER  = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_req,
   input  logic             div_req,
   input  logic             div_zero,
   output logic             mu_init,
   output logic             mu_step,
   output logic             du_init,
   output logic             du_step,
   output logic             hilo_write,
   output logic             hi_src,
   output logic             lo_src,
   output logic             busy,
   output logic             done,
   output logic             div_zero_exc,
   output logic [CNT_W-1:0] step_cnt
);
   typedef enum logic [2:0] {IDLE, INIT, RUN, WRITE, DONE, DZEXC} state_t;
   state_t           state, state_nx;
   logic             op, op_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic             last;
   assign last = step_cnt == CNT_W'(ITER - 1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= IDLE;
         op       <= 1'b0;
         step_cnt <= '0;
      end else begin
         state    <= state_nx;
         op       <= op_nx;
         step_cnt <= cnt_nx;
      end
   // A zero-divisor DIV never touches op, so hi_src keeps the last real result's source
   always_comb begin
      state_nx = state;
      op_nx    = op;
      cnt_nx   = step_cnt;
      case (state)
         IDLE:
            if (mult_req) begin
               state_nx = INIT;
               op_nx    = 1'b0;
            end else if (div_req) begin
               state_nx = div_zero ? DZEXC : INIT;
               op_nx    = div_zero ? op : 1'b1;
            end
         INIT: begin
            state_nx = RUN;
            cnt_nx   = '0;
         end
         RUN: begin
            state_nx = last ? WRITE : RUN;
            cnt_nx   = last ? '0 : step_cnt + CNT_W'(1);
         end
         WRITE:   state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      mu_init      = state == INIT && !op;
      du_init      = state == INIT && op;
      mu_step      = state == RUN && !op;
      du_step      = state == RUN && op;
      hilo_write   = state == WRITE;
      done         = state == DONE;
      div_zero_exc = state == DZEXC;
      busy         = state != IDLE;
      hi_src       = op;
      lo_src       = op;
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed plus random requests checked cycle by cycle
// against a latency-table model of the MULT/DIV sequence.
module tb_muldiv_sequencer;
   localparam int ITER  = 32;
   localparam int CNT_W = 6;
   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             mult_req = 1'b0, div_req = 1'b0, div_zero = 1'b0;
   logic             mu_init, mu_step, du_init, du_step, hilo_write;
   logic             hi_src, lo_src, busy, done, div_zero_exc;
   logic [CNT_W-1:0] step_cnt;
   int               errors = 0, checks = 0;
   int               m_c = 0;
   logic             m_op = 1'b0, m_dz = 1'b0;

   muldiv_sequencer #(.ITER(ITER), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .mult_req(mult_req), .div_req(div_req),
      .div_zero(div_zero), .mu_init(mu_init), .mu_step(mu_step),
      .du_init(du_init), .du_step(du_step), .hilo_write(hilo_write),
      .hi_src(hi_src), .lo_src(lo_src), .busy(busy), .done(done),
      .div_zero_exc(div_zero_exc), .step_cnt(step_cnt)
   );

   always #5 clk = ~clk;

   // Expected outputs from the cycle index m_c since acceptance (0 = idle)
   function automatic logic [15:0] expected();
      logic act, stp;
      act = m_c != 0 && !m_dz;
      stp = act && m_c >= 2 && m_c <= ITER + 1;
      return {act && m_c == 1 && !m_op, stp && !m_op, act && m_c == 1 && m_op,
              stp && m_op, act && m_c == ITER + 2, m_op, m_op, m_c != 0,
              act && m_c == ITER + 3, m_dz && m_c == 1,
              stp ? 6'(m_c - 2) : 6'd0};
   endfunction

   task automatic check(input string tag);
      logic [15:0] got, exp;
      exp = expected();
      got = {mu_init, mu_step, du_init, du_step, hilo_write, hi_src, lo_src,
             busy, done, div_zero_exc, step_cnt};
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
      checks++;
      assert ($onehot0({mu_init, mu_step, du_init, du_step})) else begin
         errors++;
         $error("FAIL %s_onehot: observed=%b expected=at most one", tag,
                {mu_init, mu_step, du_init, du_step});
      end
   endtask

   task automatic cyc(input logic m, input logic d, input logic z, input string tag);
      mult_req = m;
      div_req  = d;
      div_zero = z;
      @(posedge clk);
      if (reset) begin
         if (m_c == 0) begin
            if (m) begin
               m_c = 1; m_op = 1'b0; m_dz = 1'b0;
            end else if (d) begin
               m_c = 1; m_dz = z;
               if (!z) m_op = 1'b1;
            end
         end else
            m_c = (m_c == (m_dz ? 1 : ITER + 3)) ? 0 : m_c + 1;
      end
      #1;
      mult_req = 1'b0;
      div_req  = 1'b0;
      div_zero = 1'b0;
      check(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      #1;
      check("reset_t0");
      cyc(1'b1, 1'b0, 1'b0, "in_reset");
      cyc(1'b0, 1'b1, 1'b0, "in_reset");
      reset = 1'b1;
      idle(2, "post_reset_idle");
      cyc(1'b1, 1'b0, 1'b0, "mult");
      idle(ITER + 4, "mult");
      cyc(1'b0, 1'b1, 1'b0, "div");
      idle(ITER + 4, "div");
      cyc(1'b0, 1'b1, 1'b1, "divzero");
      cyc(1'b1, 1'b0, 1'b0, "dz_req_ignored");
      cyc(1'b1, 1'b0, 1'b0, "after_dz_mult");
      idle(ITER + 4, "after_dz_mult");
      cyc(1'b0, 1'b1, 1'b0, "div2");
      idle(ITER + 4, "div2");
      cyc(1'b0, 1'b1, 1'b1, "divzero_keep_src");
      idle(2, "divzero_keep_src");
      cyc(1'b1, 1'b1, 1'b1, "both_req");
      idle(ITER + 4, "both_req");
      cyc(1'b1, 1'b0, 1'b0, "mult_div_mid");
      idle(8, "mult_div_mid");
      cyc(1'b0, 1'b1, 1'b0, "div_in_cycle10");
      idle(ITER + 2, "mult_div_mid");
      cyc(1'b1, 1'b0, 1'b0, "mult_abort");
      idle(16, "mult_abort");
      checks++;
      assert (step_cnt === 6'd15) else begin
         errors++;
         $error("FAIL abort_point: observed=%0d expected=15", step_cnt);
      end
      reset = 1'b0;
      #1;
      m_c = 0; m_op = 1'b0; m_dz = 1'b0;
      check("async_reset");
      cyc(1'b0, 1'b0, 1'b0, "held_reset");
      reset = 1'b1;
      idle(3, "after_abort");
      cyc(1'b1, 1'b0, 1'b0, "mult_after_abort");
      idle(ITER + 4, "mult_after_abort");
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(0, 15);
         cyc(r == 0 || r == 3, r == 1 || r == 2 || r == 3, $urandom_range(0, 2) == 0,
             $sformatf("rand_%0d", i));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
